// File: rtl/ex_fwd_exmem_pkg.sv
// rtl/ex_fwd_exmem_pkg.sv - shared constants for the execute-stage slice
//
// Package ex_pkg: ALU operation codes carried on alu_ctrl, forwarding
// select codes carried on forward_a/forward_b, and the alu_op encodings
// produced by the main decoder in ID.
package ex_pkg;

  // alu_ctrl encodings
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  // Forwarding selects; 2'b11 is unused and falls back to register data
  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  // alu_op from the main decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;

endpackage

// File: rtl/ex_fwd_exmem_alu.sv
// rtl/ex_fwd_exmem_alu.sv - ALU control decode plus ALU (module ex_alu)
//
// Purely combinational.
// Ports:
//   alu_op   in  2     class of operation from the main decoder
//   funct3   in  3     instruction bits 14:12
//   funct7b5 in  1     instruction bit 30
//   a, b     in  XLEN  operands
//   alu_ctrl out 4     decoded operation
//   result   out XLEN  ALU result
//   zero     out 1     result == 0
module ex_alu
  import ex_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [1:0]      alu_op,
  input  logic [2:0]      funct3,
  input  logic            funct7b5,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [3:0]      alu_ctrl,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  logic [5:0] shamt;
  assign shamt = b[5:0];

  always_comb begin
    alu_ctrl = ALU_ADD;
    unique case (alu_op)
      ALUOP_ADD: alu_ctrl = ALU_ADD;
      ALUOP_SUB: alu_ctrl = ALU_SUB;
      default: begin
        unique case (funct3)
          // Immediate forms have no SUB: bit 30 is part of the immediate
          3'b000:  alu_ctrl = (alu_op == ALUOP_RTYPE && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_ctrl = ALU_SLL;
          3'b010:  alu_ctrl = ALU_SLT;
          3'b011:  alu_ctrl = ALU_SLTU;
          3'b100:  alu_ctrl = ALU_XOR;
          3'b101:  alu_ctrl = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  alu_ctrl = ALU_OR;
          default: alu_ctrl = ALU_AND;
        endcase
      end
    endcase
  end

  always_comb begin
    result = '0;
    case (alu_ctrl)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_SLL:  result = a << shamt;
      ALU_SRL:  result = a >> shamt;
      ALU_SRA:  result = $unsigned($signed(a) >>> shamt);
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, a < b};
      default:  result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/ex_fwd_exmem.sv
// rtl/ex_fwd_exmem.sv - execute stage with operand forwarding and EX/MEM register
//
// Optional feature macro: EX_FORWARD_EN. When undefined, forward_a/forward_b
// are tied to 00 and the ALU sees rs1_data/rs2_data directly.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   pc, rs1_data, rs2_data   ID/EX operands and PC
//   rs1, rs2, rd             register indices
//   imm                      sign-extended immediate
//   funct3, funct7b5, alu_op, alu_src   ALU control inputs
//   branch, mem_read, mem_write, mem_to_reg, reg_write   ID/EX control
//   wb_reg_write, wb_rd, wb_data        MEM/WB write-back port
//   forward_a, forward_b     forwarding selects
//   alu_ctrl                 decoded ALU operation
//   mem_*                    EX/MEM register outputs
module ex_fwd_exmem
  import ex_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [RA_W-1:0] rs1,
  input  logic [RA_W-1:0] rs2,
  input  logic [RA_W-1:0] rd,
  input  logic [XLEN-1:0] imm,
  input  logic [2:0]      funct3,
  input  logic            funct7b5,
  input  logic [1:0]      alu_op,
  input  logic            alu_src,
  input  logic            branch,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic            mem_to_reg,
  input  logic            reg_write,
  input  logic            wb_reg_write,
  input  logic [RA_W-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [1:0]      forward_a,
  output logic [1:0]      forward_b,
  output logic [3:0]      alu_ctrl,
  output logic            mem_branch,
  output logic            mem_mem_read,
  output logic            mem_mem_write,
  output logic            mem_mem_to_reg,
  output logic            mem_reg_write,
  output logic [XLEN-1:0] mem_pc_branch,
  output logic [XLEN-1:0] mem_alu_result,
  output logic            mem_zero,
  output logic [XLEN-1:0] mem_store_data,
  output logic [RA_W-1:0] mem_rd
);

  logic            branch_q, mem_read_q, mem_write_q, mem_to_reg_q, reg_write_q;
  logic [XLEN-1:0] pc_branch_q, alu_result_q, store_data_q;
  logic            zero_q;
  logic [RA_W-1:0] rd_q;

  logic [XLEN-1:0] op_a, op_b, fwd_rs2;
  logic [XLEN-1:0] alu_result, pc_branch;
  logic            alu_zero;

`ifdef EX_FORWARD_EN
  // EX/MEM is the younger producer, so it wins over MEM/WB. x0 never forwards.
  function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] rs,
                                         input logic            exm_we,
                                         input logic [RA_W-1:0] exm_rd,
                                         input logic            mwb_we,
                                         input logic [RA_W-1:0] mwb_rd);
    if (exm_we && exm_rd != '0 && exm_rd == rs)
      return FWD_EXMEM;
    else if (mwb_we && mwb_rd != '0 && mwb_rd == rs)
      return FWD_MEMWB;
    else
      return FWD_REG;
  endfunction

  function automatic logic [XLEN-1:0] fwd_mux(input logic [1:0]      sel,
                                              input logic [XLEN-1:0] reg_val,
                                              input logic [XLEN-1:0] exm_val,
                                              input logic [XLEN-1:0] mwb_val);
    case (sel)
      FWD_EXMEM: return exm_val;
      FWD_MEMWB: return mwb_val;
      default:   return reg_val;
    endcase
  endfunction

  assign forward_a = fwd_sel(rs1, reg_write_q, rd_q, wb_reg_write, wb_rd);
  assign forward_b = fwd_sel(rs2, reg_write_q, rd_q, wb_reg_write, wb_rd);
  assign op_a      = fwd_mux(forward_a, rs1_data, alu_result_q, wb_data);
  assign fwd_rs2   = fwd_mux(forward_b, rs2_data, alu_result_q, wb_data);
`else
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{rs1, rs2, wb_reg_write, wb_rd, wb_data};

  assign forward_a = FWD_REG;
  assign forward_b = FWD_REG;
  assign op_a      = rs1_data;
  assign fwd_rs2   = rs2_data;
`endif

  assign op_b      = alu_src ? imm : fwd_rs2;
  assign pc_branch = pc + imm;

  ex_alu #(.XLEN(XLEN)) u_alu (
    .alu_op   (alu_op),
    .funct3   (funct3),
    .funct7b5 (funct7b5),
    .a        (op_a),
    .b        (op_b),
    .alu_ctrl (alu_ctrl),
    .result   (alu_result),
    .zero     (alu_zero)
  );

  // No stall or enable: the EX/MEM register loads every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_q     <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      reg_write_q  <= 1'b0;
      pc_branch_q  <= '0;
      alu_result_q <= '0;
      zero_q       <= 1'b0;
      store_data_q <= '0;
      rd_q         <= '0;
    end else begin
      branch_q     <= branch;
      mem_read_q   <= mem_read;
      mem_write_q  <= mem_write;
      mem_to_reg_q <= mem_to_reg;
      reg_write_q  <= reg_write;
      pc_branch_q  <= pc_branch;
      alu_result_q <= alu_result;
      zero_q       <= alu_zero;
      store_data_q <= fwd_rs2;
      rd_q         <= rd;
    end
  end

  assign mem_branch     = branch_q;
  assign mem_mem_read   = mem_read_q;
  assign mem_mem_write  = mem_write_q;
  assign mem_mem_to_reg = mem_to_reg_q;
  assign mem_reg_write  = reg_write_q;
  assign mem_pc_branch  = pc_branch_q;
  assign mem_alu_result = alu_result_q;
  assign mem_zero       = zero_q;
  assign mem_store_data = store_data_q;
  assign mem_rd         = rd_q;

endmodule

// File: tb/tb_ex_fwd_exmem.sv
// tb/tb_ex_fwd_exmem.sv - self-checking bench for ex_fwd_exmem
module tb_ex_fwd_exmem;

`ifdef EX_FORWARD_EN
  localparam bit FWD_ON = 1'b1;
`else
  localparam bit FWD_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] pc, rs1_data, rs2_data, imm, wb_data;
  logic [4:0]  rs1, rs2, rd, wb_rd;
  logic [2:0]  funct3;
  logic        funct7b5, alu_src;
  logic [1:0]  alu_op;
  logic        branch, mem_read, mem_write, mem_to_reg, reg_write, wb_reg_write;
  logic [1:0]  forward_a, forward_b;
  logic [3:0]  alu_ctrl;
  logic        mem_branch, mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_reg_write;
  logic [63:0] mem_pc_branch, mem_alu_result, mem_store_data;
  logic        mem_zero;
  logic [4:0]  mem_rd;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model of the EX/MEM stage contents
  logic [63:0] m_res, m_br, m_store;
  logic [4:0]  m_rd;
  logic        m_zero, m_rw, m_b, m_mr, m_mw, m_m2r;

  ex_fwd_exmem dut (
    .clk(clk), .rst(rst), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .funct3(funct3), .funct7b5(funct7b5),
    .alu_op(alu_op), .alu_src(alu_src), .branch(branch), .mem_read(mem_read),
    .mem_write(mem_write), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .forward_a(forward_a), .forward_b(forward_b), .alu_ctrl(alu_ctrl),
    .mem_branch(mem_branch), .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .mem_mem_to_reg(mem_mem_to_reg), .mem_reg_write(mem_reg_write),
    .mem_pc_branch(mem_pc_branch), .mem_alu_result(mem_alu_result), .mem_zero(mem_zero),
    .mem_store_data(mem_store_data), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (!FWD_ON) return 2'd0;
    if (m_rw && m_rd != 0 && m_rd == rs) return 2'd2;
    if (wb_reg_write && wb_rd != 0 && wb_rd == rs) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [63:0] ref_operand(input logic [1:0] f, input logic [63:0] regv);
    if (f == 2'd2) return m_res;
    if (f == 2'd1) return wb_data;
    return regv;
  endfunction

  function automatic logic [3:0] ref_ctrl(input logic [1:0] op, input logic [2:0] f3, input logic f7);
    logic [3:0] tbl [8];
    tbl = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};
    if (op == 2'b00) return 4'd0;
    if (op == 2'b01) return 4'd1;
    if (f3 == 3'd0 && op == 2'b10 && f7) return 4'd1;
    if (f3 == 3'd5 && f7) return 4'd7;
    return tbl[f3];
  endfunction

  function automatic logic [63:0] ref_alu(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                                          input logic [63:0] a, input logic [63:0] b);
    logic signed [63:0] sa;
    int sh;
    sa = a;
    sh = int'(b[5:0]);
    if (op == 2'b00) return a + b;
    if (op == 2'b01) return a - b;
    case (f3)
      3'd0: return (op == 2'b10 && f7) ? a - b : a + b;
      3'd1: return a << sh;
      3'd2: return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      3'd3: return (a < b) ? 64'd1 : 64'd0;
      3'd4: return a ^ b;
      3'd5: return f7 ? 64'(sa >>> sh) : a >> sh;
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  task automatic check_regs(input string tag);
    chk({tag, ".alu_result"}, mem_alu_result, m_res);
    chk({tag, ".zero"},       {63'd0, mem_zero}, {63'd0, m_zero});
    chk({tag, ".pc_branch"},  mem_pc_branch, m_br);
    chk({tag, ".store_data"}, mem_store_data, m_store);
    chk({tag, ".rd"},         {59'd0, mem_rd}, {59'd0, m_rd});
    chk({tag, ".ctl"}, {59'd0, mem_branch, mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_reg_write},
                       {59'd0, m_b, m_mr, m_mw, m_m2r, m_rw});
  endtask

  // Inputs are already applied; check combinational outputs, clock, check EX/MEM.
  task automatic step(input string tag);
    logic [1:0]  fa, fb;
    logic [63:0] a, s2, b, r;
    #2;
    fa = ref_fwd(rs1);
    fb = ref_fwd(rs2);
    a  = ref_operand(fa, rs1_data);
    s2 = ref_operand(fb, rs2_data);
    b  = alu_src ? imm : s2;
    r  = ref_alu(alu_op, funct3, funct7b5, a, b);
    chk({tag, ".forward_a"}, {62'd0, forward_a}, {62'd0, fa});
    chk({tag, ".forward_b"}, {62'd0, forward_b}, {62'd0, fb});
    chk({tag, ".alu_ctrl"},  {60'd0, alu_ctrl}, {60'd0, ref_ctrl(alu_op, funct3, funct7b5)});
    @(posedge clk);
    #1;
    m_res = r; m_zero = (r == 64'd0); m_br = pc + imm; m_store = s2; m_rd = rd;
    m_rw = reg_write; m_b = branch; m_mr = mem_read; m_mw = mem_write; m_m2r = mem_to_reg;
    check_regs(tag);
  endtask

  task automatic clear_model();
    m_res = 0; m_zero = 0; m_br = 0; m_store = 0; m_rd = 0;
    m_rw = 0; m_b = 0; m_mr = 0; m_mw = 0; m_m2r = 0;
  endtask

  task automatic idle_inputs();
    pc = 0; rs1_data = 0; rs2_data = 0; imm = 0; wb_data = 0;
    rs1 = 0; rs2 = 0; rd = 0; wb_rd = 0; funct3 = 0; funct7b5 = 0;
    alu_op = 2'b00; alu_src = 0; branch = 0; mem_read = 0; mem_write = 0;
    mem_to_reg = 0; reg_write = 0; wb_reg_write = 0;
  endtask

  initial begin
    idle_inputs();
    clear_model();
    rst = 1'b1;
    #2;
    check_regs("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    m_zero = 1'b1;  // idle inputs: 0 + 0
    check_regs("idle");

    // No hazard: 5 + 7
    idle_inputs();
    rs1_data = 5; rs2_data = 7; alu_op = 2'b10; rs1 = 1; rs2 = 2;
    step("nohaz");
    chk("nohaz.result_const", mem_alu_result, 64'd12);

    // EX/MEM forward: x3 = 5 + 7, then sub x?, x3, x2 with stale rs1_data
    idle_inputs();
    rs1_data = 5; rs2_data = 7; alu_op = 2'b10; rs1 = 1; rs2 = 2; rd = 3; reg_write = 1;
    step("wr_x3");
    idle_inputs();
    rs1 = 3; rs1_data = 0; rs2 = 2; rs2_data = 2; alu_op = 2'b10; funct7b5 = 1; rd = 5;
    step("exmem_fwd");
    if (FWD_ON) chk("exmem_fwd.result_const", mem_alu_result, 64'd10);

    // Double hazard: EX/MEM holds x4 = 20, MEM/WB also writes x4 = 99
    idle_inputs();
    rs1_data = 20; alu_op = 2'b00; rd = 4; reg_write = 1;
    step("wr_x4");
    idle_inputs();
    rs1 = 4; rs1_data = 1; alu_op = 2'b00; wb_reg_write = 1; wb_rd = 4; wb_data = 99;
    step("dbl_haz");
    if (FWD_ON) chk("dbl_haz.result_const", mem_alu_result, 64'd20);

    // x0 guard: EX/MEM writes x0, consumer reads x0
    idle_inputs();
    rs1_data = 33; alu_op = 2'b00; rd = 0; reg_write = 1;
    step("wr_x0");
    idle_inputs();
    rs1 = 0; rs1_data = 0; rs2 = 0; rs2_data = 0; alu_op = 2'b00;
    wb_reg_write = 1; wb_rd = 0; wb_data = 77;
    step("x0_guard");

    // Branch: 8 - 8, target 0x40 + 0x10
    idle_inputs();
    rs1_data = 8; rs2_data = 8; rs1 = 6; rs2 = 7; alu_op = 2'b01; branch = 1;
    pc = 64'h40; imm = 64'h10;
    step("branch");
    chk("branch.zero_const", {63'd0, mem_zero}, 64'd1);
    chk("branch.target_const", mem_pc_branch, 64'h50);

    // Randomised traffic with a small register window to provoke hazards
    for (int i = 0; i < 300; i++) begin
      pc       = {$urandom, $urandom};
      imm      = ($urandom_range(0, 3) == 0) ? 64'd0 - 64'($urandom_range(0, 64)) : 64'($urandom_range(0, 70));
      rs1_data = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 15));
      rs2_data = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 15));
      wb_data  = {$urandom, $urandom};
      rs1 = 5'($urandom_range(0, 3)); rs2 = 5'($urandom_range(0, 3));
      rd  = 5'($urandom_range(0, 3)); wb_rd = 5'($urandom_range(0, 3));
      funct3 = 3'($urandom_range(0, 7)); funct7b5 = 1'($urandom_range(0, 1));
      alu_op = 2'($urandom_range(0, 3)); alu_src = 1'($urandom_range(0, 1));
      branch = 1'($urandom_range(0, 1)); mem_read = 1'($urandom_range(0, 1));
      mem_write = 1'($urandom_range(0, 1)); mem_to_reg = 1'($urandom_range(0, 1));
      reg_write = 1'($urandom_range(0, 1)); wb_reg_write = 1'($urandom_range(0, 1));
      step("rand");
    end

    // Load a nonzero state, then reset asynchronously between edges
    idle_inputs();
    rs1_data = 9; alu_op = 2'b00; rd = 2; reg_write = 1; mem_read = 1; branch = 1;
    pc = 64'h100; imm = 64'h4; rs2_data = 3;
    step("pre_rst");
    #3;
    rst = 1'b1;
    #1;
    clear_model();
    check_regs("async_rst");
    #1;
    rst = 1'b0;
    idle_inputs();
    rs1 = 2; rs1_data = 3; rs2_data = 4; alu_op = 2'b10;
    step("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ex_fwd_exmem.md
Name: ex_fwd_exmem

Overview:
- Execute-stage slice of the 5-stage 64-bit RISC-V pipeline, sitting between the ID/EX register and the memory-access stage.
- Contains three parts: operand forwarding (hazard resolution against EX/MEM and MEM/WB), ALU control plus ALU, and branch-target adder.
- Results are captured in the EX/MEM pipeline register; the registered rd and reg_write feed back into the forwarding logic.

Parameters:
- XLEN, 64, datapath width.
- RA_W, 5, register-address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- pc  in  XLEN  PC of the instruction in EX (from ID/EX)
- rs1_data, rs2_data  in  XLEN  register-file operands (from ID/EX)
- rs1, rs2, rd  in  RA_W  source/destination register indices
- imm  in  XLEN  sign-extended immediate, byte offset
- funct3  in  3  instruction bits 14:12
- funct7b5  in  1  instruction bit 30
- alu_op  in  2  00 add, 01 sub/branch, 10 R-type, 11 I-type ALU
- alu_src  in  1  1 selects imm as operand B
- branch, mem_read, mem_write, mem_to_reg, reg_write  in  1 each  control from ID/EX
- wb_reg_write  in  1  MEM/WB write enable
- wb_rd  in  RA_W  MEM/WB destination register
- wb_data  in  XLEN  final write-back value
- forward_a, forward_b  out  2  forwarding selects (observability)
- alu_ctrl  out  4  decoded ALU operation (combinational)
- mem_branch, mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_reg_write  out  1 each  registered control
- mem_pc_branch  out  XLEN  registered branch target
- mem_alu_result  out  XLEN  registered ALU result
- mem_zero  out  1  registered zero flag
- mem_store_data  out  XLEN  registered forwarded rs2
- mem_rd  out  RA_W  registered destination register

Behaviour:
- Reset: rst is asynchronous and active-high, clock is clk. Reset clears every registered output to 0.
- forward_a is combinational:
  - 10 if mem_reg_write and mem_rd != 0 and mem_rd == rs1.
  - Else 01 if wb_reg_write and wb_rd != 0 and wb_rd == rs1.
  - Else 00.
  - forward_b follows the same rule with rs2.
  - EX/MEM has priority when both stages match.
- Operand select by forward code: 00 = register data, 10 = mem_alu_result, 01 = wb_data, 11 = register data.
- Operand A is always the forwarded rs1. Operand B is imm if alu_src is 1, otherwise the forwarded rs2. Store data is always the forwarded rs2.
- alu_ctrl encodings: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SRA, 1000 SLT, 1001 SLTU.
  - alu_op 00 gives ADD; alu_op 01 gives SUB.
  - alu_op 10 and 11 decode funct3: 000 ADD, or SUB if alu_op=10 and funct7b5=1; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRL, or SRA if funct7b5=1; 110 OR; 111 AND.
- ALU arithmetic:
  - Arithmetic wraps modulo 2^XLEN.
  - Shift amount is operand B[5:0].
  - SLT is a signed compare; SLTU is unsigned. Both return 1 or 0.
- zero = (alu result == 0). pc_branch = pc + imm, wrapping.
- All EX/MEM fields latch on every posedge clk. Latency is 1 cycle; there is no stall or enable.
- Load-use bubbles arrive as zeroed control inputs from upstream.
- A reset during operation clears the register immediately, with no clock needed.

Optional Feature:
- Macro EX_FORWARD_EN.
- Defined: forwarding operates as described above.
- Undefined: forward_a and forward_b are tied to 00 and operands come straight from rs1_data/rs2_data. Software must then insert NOPs between dependent instructions.

Decomposition:
- Shared package ex_pkg holds:
  - the ALU_ADD..ALU_SLTU alu_ctrl constants;
  - the FWD_REG/FWD_EXMEM/FWD_MEMWB select constants;
  - the ALUOP_* encodings.
- One sub-module, ex_alu: ALU plus ALU-control decode, purely combinational.
- Forwarding logic and the EX/MEM register stay in the top module.

Test Plan:
- No hazard: rs1_data=5, rs2_data=7, alu_op=10, funct3=000, funct7b5=0, rs1=1, rs2=2, no matching rd in later stages -> after posedge, mem_alu_result=12, forward_a=forward_b=00.
- EX/MEM forward: cycle 1 writes x3=12 (reg_write=1, rd=3); cycle 2 sub with rs1=3 and stale rs1_data=0, rs2_data=2 -> forward_a=10, mem_alu_result=10.
- Double hazard priority: mem_rd=wb_rd=4, wb_data=99, mem_alu_result=20, rs1=4 -> forward_a=10, operand A=20.
- x0 guard: mem_rd=0, mem_reg_write=1, rs1=0 -> forward_a=00.
- Branch: alu_op=01, both operands 8, pc=0x40, imm=0x10 -> mem_zero=1, mem_pc_branch=0x50.
- Async reset: assert rst between clock edges -> all mem_* outputs 0 immediately.
